pcs_tx_gearbox: RTL and testbench
=================================

Name: pcs_tx_gearbox

Overview:
- TX gearbox between the 64b/66b encoder/scrambler and the GTY transceiver TX port.
- Accepts 66-bit blocks as two 32-bit words (sync header with the first word) and emits one continuous 32-bit word per cycle.
- Throttles upstream with a 2-cycle pause every 66 cycles, the same pause the XGMII side of the PCS observes.

Parameters:
- DATA_WIDTH, 32, data width of input and output words (only 32 is supported).
- HDR_WIDTH, 2, sync header width.
- SEQ_PERIOD, 66, gearbox sequence length in cycles (64 data cycles + 2 pause cycles).

Ports:
- i_clk  in  1  PCS TX clock; the only clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_tx_data  in  32  scrambled payload half-block; word 0 = payload[31:0], word 1 = payload[63:32].
- i_tx_hdr  in  2  sync header; sampled only in phase-0 cycles (01 = data, 10 = control).
- i_tx_valid  in  1  upstream word valid.
- o_tx_pause  out  1  combinational from registered state; high means upstream must not present a word this cycle.
- o_tx_phase  out  1  0 = first half of a block expected, 1 = second half.
- o_gearbox_data  out  32  word to GTY; bit 0 is transmitted first.
- o_tx_underflow  out  1  one-cycle pulse: a non-pause slot had i_tx_valid low.

Behaviour:
- Decided interface: one clock (i_clk); reset i_reset is asynchronous and active-high.
- Reset values: seq_cnt=0, occ=0, leftover=0, o_gearbox_data=0, o_tx_underflow=0. Outputs after reset: o_tx_pause=0, o_tx_phase=0.
- seq_cnt (7 bits):
  - Free-running 0..65, wraps 65→0.
  - o_tx_pause = (seq_cnt >= 64).
  - o_tx_phase = seq_cnt[0].
- Serialisation order: the 66-bit block is {payload[63:0], hdr[1:0]}, sent LSB first (header bits first).
- Per non-pause cycle:
  - new = phase 0 ? {i_tx_data, i_tx_hdr} (34 b) : i_tx_data (32 b).
  - combined = (new << occ) | leftover.
  - o_gearbox_data <= combined[31:0].
  - leftover <= combined >> 32.
  - occ <= occ + |new| − 32, i.e. +2 in phase 0, +0 in phase 1.
- Per pause cycle: o_gearbox_data <= leftover[31:0]; leftover >>= 32; occ −= 32.
- occ sequence:
  - 0 at seq 0; 2k+2 after phase 0 of block k; 64 after block 31 (seq 63); 32 after seq 64; 0 after seq 65.
  - Maximum combined width is 96 bits; leftover register is 64 bits.
- Latency: one cycle from word accept to its first bits appearing on o_gearbox_data.
- Underflow: i_tx_valid low in a non-pause slot:
  - Substitute word 0, with header 00 in phase 0.
  - Pulse o_tx_underflow.
  - seq/occ advance normally; line rate is never broken.
- i_tx_valid high during pause: word ignored, no error; upstream must re-present it after the pause.
- Reset mid-sequence: all state cleared asynchronously. The first cycle after release is seq 0, phase 0.
- No back-pressure exists from the GTY side.

Decomposition:
- pcs_pkg holds:
  - constants PCS_DATA_WIDTH=32, PCS_HDR_WIDTH=2, GEARBOX_SEQ_PERIOD=66, GEARBOX_PAUSE_START=64, SYNC_HDR_DATA=2'b01, SYNC_HDR_CTRL=2'b10;
  - typedef pcs_block_t (struct: hdr[1:0], payload[63:0]).
- One natural sub-module: pcs_gearbox_seq, the 0..65 sequence counter producing pause/phase. The shift/merge datapath stays in the top module.

Test Plan:
- Reset release, stream block hdr=01, payload=64'hFEDCBA98_76543210 → o_gearbox_data, one cycle after each word:
  - after word 0: 32'hD950C841 ({payload[29:0], 2'b01});
  - after word 1: 32'hFB72EA61 ({payload[61:32], payload[31:30]}).
- Continuous valid for 66 cycles → o_tx_pause high exactly at seq 64,65.
- Continuous stream, drain check: output in the two pause cycles equals the 64 leftover bits, i.e. bits 2048..2111 of the 32-block serial stream.
- Continuous stream, reassembly: a reference model shifts the 32-bit output stream into 66-bit blocks; all 32×N blocks match, with header positions aligned from bit 0 after reset.
- Drop i_tx_valid at seq 10 → o_tx_underflow pulses for 1 cycle; the corresponding block decodes to hdr 00 / zero half; subsequent blocks remain aligned.
- Hold i_tx_valid high through the pause with changing data → those words are absent from output, no underflow pulse.
- Assert i_reset at seq 37 mid-block → o_gearbox_data=0 and o_tx_pause=0 immediately. After release, first block output matches the first scenario.

Source files
------------

// File: rtl/pcs_pkg.sv
// rtl/pcs_pkg.sv - shared PCS constants and block type for the TX gearbox path
package pcs_pkg;

   localparam int PCS_DATA_WIDTH      = 32;
   localparam int PCS_HDR_WIDTH       = 2;
   localparam int GEARBOX_SEQ_PERIOD  = 66;
   localparam int GEARBOX_PAUSE_START = 64;

   localparam logic [1:0] SYNC_HDR_DATA = 2'b01;
   localparam logic [1:0] SYNC_HDR_CTRL = 2'b10;

   typedef struct packed {
      logic [1:0]  hdr;
      logic [63:0] payload;
   } pcs_block_t;

endpackage

// File: rtl/pcs_gearbox_seq.sv
// rtl/pcs_gearbox_seq.sv - free-running 0..SEQ_PERIOD-1 gearbox sequence counter
module pcs_gearbox_seq
   import pcs_pkg::*;
#(
   parameter int SEQ_PERIOD = GEARBOX_SEQ_PERIOD
) (
   input  logic i_clk,
   input  logic i_reset,
   output logic tx_pause,
   output logic tx_phase
);

   logic [6:0] seq_cnt;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         seq_cnt <= '0;
      end else if (seq_cnt == 7'(SEQ_PERIOD - 1)) begin
         seq_cnt <= '0;
      end else begin
         seq_cnt <= seq_cnt + 7'd1;
      end
   end

   // The last two slots of every period carry no new upstream word.
   assign tx_pause = (seq_cnt >= 7'(GEARBOX_PAUSE_START));
   assign tx_phase = seq_cnt[0];

endmodule

// File: rtl/pcs_tx_gearbox.sv
// rtl/pcs_tx_gearbox.sv - 66b block to continuous 32b word TX gearbox
module pcs_tx_gearbox
   import pcs_pkg::*;
#(
   parameter int DATA_WIDTH = PCS_DATA_WIDTH,
   parameter int HDR_WIDTH  = PCS_HDR_WIDTH,
   parameter int SEQ_PERIOD = GEARBOX_SEQ_PERIOD
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [DATA_WIDTH-1:0] i_tx_data,
   input  logic [HDR_WIDTH-1:0]  i_tx_hdr,
   input  logic                  i_tx_valid,
   output logic                  o_tx_pause,
   output logic                  o_tx_phase,
   output logic [DATA_WIDTH-1:0] o_gearbox_data,
   output logic                  o_tx_underflow
);

   localparam int CW = 3 * DATA_WIDTH;
   localparam int LW = 2 * DATA_WIDTH;

   logic [6:0]            occ;
   logic [6:0]            occ_next;
   logic [LW-1:0]         leftover;
   logic [CW-1:0]         new_bits;
   logic [CW-1:0]         combined;
   logic [DATA_WIDTH-1:0] blk_data;
   logic [HDR_WIDTH-1:0]  blk_hdr;

   pcs_gearbox_seq #(
      .SEQ_PERIOD (SEQ_PERIOD)
   ) u_seq (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .tx_pause (o_tx_pause),
      .tx_phase (o_tx_phase)
   );

   always_comb begin
      blk_data = '0;
      blk_hdr  = '0;
      new_bits = '0;
      combined = {{DATA_WIDTH{1'b0}}, leftover};
      occ_next = occ - 7'(DATA_WIDTH);
      // A missing word still consumes its slot as zeros so line rate never breaks.
      if (i_tx_valid) begin
         blk_data = i_tx_data;
         blk_hdr  = i_tx_hdr;
      end
      if (!o_tx_pause) begin
         if (!o_tx_phase) begin
            new_bits = {{(CW-DATA_WIDTH-HDR_WIDTH){1'b0}}, blk_data, blk_hdr};
            occ_next = occ + 7'(HDR_WIDTH);
         end else begin
            new_bits = {{(CW-DATA_WIDTH){1'b0}}, blk_data};
            occ_next = occ;
         end
         combined = (new_bits << occ) | {{DATA_WIDTH{1'b0}}, leftover};
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         occ            <= '0;
         leftover       <= '0;
         o_gearbox_data <= '0;
         o_tx_underflow <= 1'b0;
      end else begin
         occ            <= occ_next;
         leftover       <= combined[CW-1:DATA_WIDTH];
         o_gearbox_data <= combined[DATA_WIDTH-1:0];
         o_tx_underflow <= !o_tx_pause && !i_tx_valid;
      end
   end

endmodule

// File: tb/tb_pcs_tx_gearbox.sv
// tb/tb_pcs_tx_gearbox.sv - directed self-checking bench for pcs_tx_gearbox
module tb_pcs_tx_gearbox;
   import pcs_pkg::*;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic [31:0] i_tx_data;
   logic [1:0]  i_tx_hdr;
   logic        i_tx_valid;
   logic        o_tx_pause;
   logic        o_tx_phase;
   logic [31:0] o_gearbox_data;
   logic        o_tx_underflow;

   int tests_run    = 0;
   int tests_failed = 0;
   int tb_seq       = 0;
   bit exp_q[$];

   pcs_tx_gearbox dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_tx_data      (i_tx_data),
      .i_tx_hdr       (i_tx_hdr),
      .i_tx_valid     (i_tx_valid),
      .o_tx_pause     (o_tx_pause),
      .o_tx_phase     (o_tx_phase),
      .o_gearbox_data (o_gearbox_data),
      .o_tx_underflow (o_tx_underflow)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h (seq %0d)", tag, got, exp, tb_seq);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Serial-stream model: each accepted slot appends its bits LSB first,
   // each cycle removes the next 32 bits as the expected output word.
   task automatic cycle(input logic v, input logic [31:0] d, input logic [1:0] h);
      logic [31:0] dm;
      logic [1:0]  hm;
      logic [31:0] ew;
      logic        eu;
      i_tx_valid = v;
      i_tx_data  = d;
      i_tx_hdr   = h;
      check("pause", 64'(o_tx_pause), 64'(tb_seq >= 64));
      check("phase", 64'(o_tx_phase), 64'(tb_seq % 2));
      eu = 1'b0;
      if (tb_seq < 64) begin
         dm = v ? d : 32'h0;
         hm = v ? h : 2'b00;
         eu = !v;
         if (tb_seq % 2 == 0) begin
            exp_q.push_back(hm[0]);
            exp_q.push_back(hm[1]);
         end
         for (int i = 0; i < 32; i++) exp_q.push_back(dm[i]);
      end
      tick();
      check("qdepth", 64'(exp_q.size() >= 32), 64'd1);
      ew = '0;
      for (int i = 0; i < 32; i++) if (exp_q.size() > 0) ew[i] = exp_q.pop_front();
      check((tb_seq >= 64) ? "drain" : "data", 64'(o_gearbox_data), 64'(ew));
      check("uflow", 64'(o_tx_underflow), 64'(eu));
      tb_seq = (tb_seq == 65) ? 0 : tb_seq + 1;
   endtask

   task automatic first_block();
      pcs_block_t blk;
      blk.hdr     = SYNC_HDR_DATA;
      blk.payload = 64'hFEDC_BA98_7654_3210;
      cycle(1'b1, blk.payload[31:0], blk.hdr);
      check("first_w0", 64'(o_gearbox_data), 64'h0000_0000_D950_C841);
      cycle(1'b1, blk.payload[63:32], blk.hdr);
      check("first_w1", 64'(o_gearbox_data), 64'h0000_0000_FB72_EA61);
   endtask

   initial begin
      int          p;
      logic        v;
      logic [31:0] d;
      logic [1:0]  h;

      i_reset    = 1'b1;
      i_tx_valid = 1'b0;
      i_tx_data  = '0;
      i_tx_hdr   = '0;
      tick();
      tick();
      check("rst_data",  64'(o_gearbox_data), 64'd0);
      check("rst_uflow", 64'(o_tx_underflow), 64'd0);
      check("rst_pause", 64'(o_tx_pause), 64'd0);
      check("rst_phase", 64'(o_tx_phase), 64'd0);
      #2;
      i_reset = 1'b0;
      tb_seq  = 0;

      first_block();

      // Period 0: continuous with data changing through pause; period 1: gap at seq 10.
      for (int c = 2; c < 66 * 3; c++) begin
         p = c / 66;
         if (p == 2 && tb_seq == 37) break;
         d = (32'h0101_0101 * 32'(c + 1)) ^ 32'hA5A5_0F0F;
         h = (((c / 2) % 2) == 1) ? SYNC_HDR_CTRL : SYNC_HDR_DATA;
         v = !(p == 1 && tb_seq == 10);
         cycle(v, d, h);
      end

      check("pre_rst_seq", 64'(tb_seq), 64'd37);
      i_reset = 1'b1;
      #1;
      check("mid_rst_data",  64'(o_gearbox_data), 64'd0);
      check("mid_rst_pause", 64'(o_tx_pause), 64'd0);
      check("mid_rst_phase", 64'(o_tx_phase), 64'd0);
      check("mid_rst_uflow", 64'(o_tx_underflow), 64'd0);
      i_tx_valid = 1'b0;
      tick();
      #2;
      i_reset = 1'b0;
      tb_seq  = 0;
      exp_q.delete();

      first_block();
      for (int c = 2; c < 70; c++) begin
         d = (32'h1357_9BDF * 32'(c + 3)) ^ 32'h0F0F_A5A5;
         h = (((c / 2) % 2) == 1) ? SYNC_HDR_DATA : SYNC_HDR_CTRL;
         cycle(1'b1, d, h);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
